// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the datapath control sequencer: opcode and ALU
// function encodings, sequencer states and opcode classification helpers.
package dp_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLT  = 5'b00101;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_LW   = 5'b01001;
    localparam logic [4:0] OP_SW   = 5'b01010;
    localparam logic [4:0] OP_BEQ  = 5'b01011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED,
        S_ERR
    } state_t;

    function automatic logic is_rtype(input logic [4:0] op);
        return (op[4:3] == 2'b00) && (op[2:0] <= 3'd5);
    endfunction

    // 010xx covers ADDI, LW, SW and BEQ
    function automatic logic is_legal(input logic [4:0] op);
        return is_rtype(op) || (op[4:2] == 3'b010) || (op == OP_HALT);
    endfunction

    function automatic logic uses_imm(input logic [4:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] alu_fn_of(input logic [4:0] op);
        case (op)
            OP_SUB, OP_BEQ: return ALU_SUB;
            OP_AND:         return ALU_AND;
            OP_OR:          return ALU_OR;
            OP_XOR:         return ALU_XOR;
            OP_SLT:         return ALU_SLT;
            default:        return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/dp_ctrl_fsm_decode.sv
// Strobe decoder: turns the sequencer state and latched opcode into the
// datapath control strobes. Only NIA in MEM looks at mem_ready.
module dp_ctrl_fsm_decode
    import dp_ctrl_pkg::*;
(
    input  logic [2:0] state,
    input  logic [4:0] op_q,
    input  logic       mem_ready,
    output logic       nia,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src,
    output logic [2:0] alu_fn,
    output logic       mem_write,
    output logic       mem_read,
    output logic       mem_to_reg
);

    state_t st;
    assign st = state_t'(state);

    always_comb begin
        nia        = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_fn     = ALU_ADD;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;

        case (st)
            S_EXEC: begin
                alu_fn  = alu_fn_of(op_q);
                alu_src = uses_imm(op_q);
                nia     = (op_q == OP_BEQ);
            end
            S_MEM: begin
                alu_fn    = alu_fn_of(op_q);
                alu_src   = uses_imm(op_q);
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                // store completes in the same cycle memory accepts it
                nia       = (op_q == OP_SW) && mem_ready;
            end
            S_WB: begin
                alu_fn     = alu_fn_of(op_q);
                alu_src    = uses_imm(op_q);
                reg_write  = 1'b1;
                nia        = 1'b1;
                reg_dst    = is_rtype(op_q);
                mem_to_reg = (op_q == OP_LW);
                mem_read   = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dp_ctrl_fsm.sv
// Multi-cycle control sequencer for the 8-bit datapath: fetch/decode/execute
// with memory ready handshake, timeout trap, single-step and retire counting.
module dp_ctrl_fsm
    import dp_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             mem_ready,
    input  logic [4:0]       OpFn,
    output logic             NIA,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic [2:0]       ALUFn,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             MemToReg,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [4:0]       op_q_reg, op_q_next;
    logic [7:0]       wait_reg, wait_next;
    logic [CNT_W-1:0] retired_reg;
    logic             retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            op_q_reg    <= '0;
            wait_reg    <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            op_q_reg  <= op_q_next;
            wait_reg  <= wait_next;
            if (retire) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        op_q_next  = op_q_reg;
        wait_next  = wait_reg;
        retire     = 1'b0;

        case (state_reg)
            S_IDLE:   if (run) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                op_q_next = OpFn;
                if (!is_legal(OpFn)) begin
                    state_next = S_ERR;
                end else if (OpFn == OP_HALT) begin
                    state_next = S_HALTED;
                    retire     = 1'b1;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if ((op_q_reg == OP_LW) || (op_q_reg == OP_SW)) begin
                    state_next = S_MEM;
                    wait_next  = '0;
                end else if (op_q_reg == OP_BEQ) begin
                    retire     = 1'b1;
                    state_next = step ? S_IDLE : S_FETCH;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                // a ready in the last allowed cycle still wins over the timeout
                if (mem_ready) begin
                    if (op_q_reg == OP_LW) begin
                        state_next = S_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = step ? S_IDLE : S_FETCH;
                    end
                end else begin
                    wait_next = wait_reg + 8'd1;
                    if (wait_reg == WAIT_LAST) begin
                        state_next = S_ERR;
                    end
                end
            end
            S_WB: begin
                retire     = 1'b1;
                state_next = step ? S_IDLE : S_FETCH;
            end
            default: ;
        endcase
    end

    dp_ctrl_fsm_decode u_decode (
        .state      (state_reg),
        .op_q       (op_q_reg),
        .mem_ready  (mem_ready),
        .nia        (NIA),
        .reg_dst    (RegDst),
        .reg_write  (RegWrite),
        .alu_src    (ALUSrc),
        .alu_fn     (ALUFn),
        .mem_write  (MemWrite),
        .mem_read   (MemRead),
        .mem_to_reg (MemToReg)
    );

    assign busy    = !((state_reg == S_IDLE) || (state_reg == S_HALTED) || (state_reg == S_ERR));
    assign halted  = (state_reg == S_HALTED);
    assign error   = (state_reg == S_ERR);
    assign retired = retired_reg;

endmodule

// File: tb/tb_dp_ctrl_fsm.sv
// Self-checking bench for dp_ctrl_fsm: an instruction-level model expands each
// directed instruction into its expected per-cycle outputs, checked every cycle.
module tb_dp_ctrl_fsm;

    localparam logic [4:0] T_ADD  = 5'b00000;
    localparam logic [4:0] T_SUB  = 5'b00001;
    localparam logic [4:0] T_AND  = 5'b00010;
    localparam logic [4:0] T_OR   = 5'b00011;
    localparam logic [4:0] T_XOR  = 5'b00100;
    localparam logic [4:0] T_SLT  = 5'b00101;
    localparam logic [4:0] T_ILL  = 5'b00110;
    localparam logic [4:0] T_ADDI = 5'b01000;
    localparam logic [4:0] T_LW   = 5'b01001;
    localparam logic [4:0] T_SW   = 5'b01010;
    localparam logic [4:0] T_BEQ  = 5'b01011;
    localparam logic [4:0] T_HALT = 5'b11111;
    localparam logic [4:0] T_JUNK = 5'b10110;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst, run, step, mem_ready;
    logic [4:0]  op_fn;
    logic        nia, reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg;
    logic [2:0]  alu_fn;
    logic        busy, halted, error;
    logic [15:0] retired;

    always #5 clk = ~clk;

    dp_ctrl_fsm #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .mem_ready (mem_ready),
        .OpFn      (op_fn),
        .NIA       (nia),
        .RegDst    (reg_dst),
        .RegWrite  (reg_write),
        .ALUSrc    (alu_src),
        .ALUFn     (alu_fn),
        .MemWrite  (mem_write),
        .MemRead   (mem_read),
        .MemToReg  (mem_to_reg),
        .busy      (busy),
        .halted    (halted),
        .error     (error),
        .retired   (retired)
    );

    typedef struct {
        logic        rst, run, step, rdy;
        logic [4:0]  op;
        logic        nia, reg_dst, reg_write, alu_src;
        logic [2:0]  alu_fn;
        logic        mem_write, mem_read, mem_to_reg, busy, halted, error;
        logic [15:0] retired;
    } vec_t;

    vec_t vq[$];
    int   m_retired;
    int   nia_exp;
    int   nia_seen;
    int   total;
    int   bad;

    // ---- specification-level opcode facts ----
    function automatic logic [2:0] spec_alu(input logic [4:0] op);
        case (op)
            T_SUB, T_BEQ: return 3'b001;
            T_AND:        return 3'b010;
            T_OR:         return 3'b011;
            T_XOR:        return 3'b100;
            T_SLT:        return 3'b101;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic logic spec_rtype(input logic [4:0] op);
        return op inside {T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_SLT};
    endfunction

    function automatic logic spec_legal(input logic [4:0] op);
        return spec_rtype(op) || (op inside {T_ADDI, T_LW, T_SW, T_BEQ, T_HALT});
    endfunction

    function automatic vec_t base(input logic run_i, input logic step_i);
        vec_t v;
        v = '{default: '0};
        v.run     = run_i;
        v.step    = step_i;
        v.op      = T_JUNK;
        v.retired = 16'(m_retired);
        return v;
    endfunction

    function automatic vec_t with_alu(input vec_t vin, input logic [4:0] op);
        vec_t v;
        v = vin;
        v.busy    = 1'b1;
        v.alu_fn  = spec_alu(op);
        v.alu_src = op inside {T_ADDI, T_LW, T_SW};
        return v;
    endfunction

    task automatic idle(input logic run_i);
        vq.push_back(base(run_i, 1'b0));
    endtask

    task automatic rst_cyc();
        vec_t v;
        m_retired = 0;
        v = base(1'b0, 1'b0);
        v.rst = 1'b1;
        vq.push_back(v);
    endtask

    task automatic retire_instr();
        m_retired = m_retired + 1;
        nia_exp   = nia_exp + 1;
    endtask

    // Expands one instruction starting at its FETCH cycle. waits = MEM cycles
    // with mem_ready low before ready; waits >= TIMEOUT means never ready.
    // abort = reset after 'waits' MEM cycles.
    task automatic instr(input logic [4:0] op, input int waits, input logic step_i,
                         input logic run_i, input logic abort);
        vec_t v;
        v = base(run_i, step_i); v.busy = 1'b1; vq.push_back(v);
        v = base(run_i, step_i); v.busy = 1'b1; v.op = op; vq.push_back(v);
        if (op == T_HALT) begin
            m_retired = m_retired + 1;
            for (int k = 0; k < 3; k++) begin
                v = base(run_i, step_i); v.halted = 1'b1; vq.push_back(v);
            end
            return;
        end
        if (!spec_legal(op)) begin
            for (int k = 0; k < 3; k++) begin
                v = base(run_i, step_i); v.error = 1'b1; vq.push_back(v);
            end
            return;
        end
        v = with_alu(base(run_i, step_i), op);
        if (op == T_BEQ) begin
            v.nia = 1'b1; vq.push_back(v); retire_instr();
            return;
        end
        vq.push_back(v);
        if (op == T_LW || op == T_SW) begin
            int n;
            n = (waits >= TIMEOUT) ? TIMEOUT : waits;
            for (int k = 0; k < n; k++) begin
                v = with_alu(base(run_i, step_i), op);
                v.mem_read = (op == T_LW); v.mem_write = (op == T_SW);
                vq.push_back(v);
            end
            if (abort) begin
                rst_cyc();
                return;
            end
            if (waits >= TIMEOUT) begin
                for (int k = 0; k < 3; k++) begin
                    v = base(run_i, step_i); v.error = 1'b1; vq.push_back(v);
                end
                return;
            end
            v = with_alu(base(run_i, step_i), op);
            v.rdy = 1'b1;
            v.mem_read = (op == T_LW); v.mem_write = (op == T_SW);
            v.nia = (op == T_SW);
            vq.push_back(v);
            if (op == T_SW) begin
                retire_instr();
                return;
            end
        end
        v = with_alu(base(run_i, step_i), op);
        v.reg_write  = 1'b1;
        v.nia        = 1'b1;
        v.reg_dst    = spec_rtype(op);
        v.mem_to_reg = (op == T_LW);
        v.mem_read   = (op == T_LW);
        vq.push_back(v);
        retire_instr();
    endtask

    function automatic logic [28:0] exp_bits(input vec_t v);
        return {v.nia, v.reg_dst, v.reg_write, v.alu_src, v.alu_fn, v.mem_write,
                v.mem_read, v.mem_to_reg, v.busy, v.halted, v.error, v.retired};
    endfunction

    function automatic logic [28:0] act_bits();
        return {nia, reg_dst, reg_write, alu_src, alu_fn, mem_write,
                mem_read, mem_to_reg, busy, halted, error, retired};
    endfunction

    initial begin
        total = 0; bad = 0; nia_seen = 0; nia_exp = 0; m_retired = 0;
        rst = 1'b1; run = 1'b0; step = 1'b0; mem_ready = 1'b0; op_fn = T_JUNK;

        // directed program
        idle(1'b0); idle(1'b0);
        idle(1'b1); instr(T_ADD, 0, 1'b0, 1'b1, 1'b0);
        instr(T_LW, 3, 1'b0, 1'b1, 1'b0);
        instr(T_SW, 0, 1'b0, 1'b1, 1'b0);
        instr(T_XOR, 0, 1'b0, 1'b1, 1'b0);
        instr(T_ADDI, 0, 1'b0, 1'b1, 1'b0);
        instr(T_SLT, 0, 1'b0, 1'b1, 1'b0);
        instr(T_AND, 0, 1'b0, 1'b1, 1'b0);
        instr(T_OR, 0, 1'b0, 1'b1, 1'b0);
        instr(T_SUB, 0, 1'b1, 1'b0, 1'b0);
        idle(1'b0); idle(1'b0);
        idle(1'b1); instr(T_BEQ, 0, 1'b1, 1'b1, 1'b0);
        idle(1'b1); instr(T_LW, TIMEOUT - 1, 1'b1, 1'b1, 1'b0);
        idle(1'b1); instr(T_SW, 2, 1'b1, 1'b1, 1'b0);
        idle(1'b1); instr(T_LW, 1, 1'b0, 1'b1, 1'b1);
        idle(1'b1); instr(T_ILL, 0, 1'b0, 1'b1, 1'b0); rst_cyc();
        idle(1'b1); instr(T_ADD, 0, 1'b0, 1'b1, 1'b0); instr(T_HALT, 0, 1'b0, 1'b1, 1'b0); rst_cyc();
        idle(1'b1); instr(T_LW, TIMEOUT, 1'b0, 1'b1, 1'b0); rst_cyc();
        idle(1'b0);

        repeat (2) @(negedge clk);
        total++;
        if (act_bits() != 29'd0) begin
            bad++;
            $display("FAIL reset_state actual=%h required=%h", act_bits(), 29'd0);
        end else begin
            $display("reset state ok");
        end

        fork
            begin : driver
                for (int i = 0; i < vq.size(); i++) begin
                    @(posedge clk);
                    #1;
                    rst = vq[i].rst; run = vq[i].run; step = vq[i].step;
                    mem_ready = vq[i].rdy; op_fn = vq[i].op;
                end
            end
            begin : compare
                for (int i = 0; i < vq.size(); i++) begin
                    @(negedge clk);
                    total++;
                    if (act_bits() != exp_bits(vq[i])) begin
                        bad++;
                        $display("FAIL cycle_%0d outputs actual=%h required=%h", i, act_bits(), exp_bits(vq[i]));
                    end else begin
                        $display("cyc %0d rst=%b run=%b step=%b op=%b rdy=%b out=%h", i,
                                 vq[i].rst, vq[i].run, vq[i].step, vq[i].op, vq[i].rdy, act_bits());
                    end
                    total++;
                    if (mem_read && mem_write) begin
                        bad++;
                        $display("FAIL cycle_%0d rd_wr_exclusive actual=11 required=not_both", i);
                    end
                    if (nia) nia_seen++;
                    // hand-computed pins on the first ADD (EXEC=5, WB=6, next FETCH=7)
                    if (i == 5) begin
                        total++;
                        if ({alu_fn, alu_src, busy} != 5'b000_0_1) begin
                            bad++;
                            $display("FAIL add_exec actual=%b required=00001", {alu_fn, alu_src, busy});
                        end
                    end
                    if (i == 6) begin
                        total++;
                        if ({reg_write, reg_dst, nia, mem_to_reg, alu_fn} != 7'b1110_000) begin
                            bad++;
                            $display("FAIL add_wb actual=%b required=1110000",
                                     {reg_write, reg_dst, nia, mem_to_reg, alu_fn});
                        end
                    end
                    if (i == 7) begin
                        total++;
                        if (retired != 16'd1 || !busy) begin
                            bad++;
                            $display("FAIL add_retired actual=%0d required=1", retired);
                        end
                    end
                end
            end
        join

        total++;
        if (nia_seen != nia_exp) begin
            bad++;
            $display("FAIL nia_pulse_count actual=%0d required=%0d", nia_seen, nia_exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
